// File: rtl/bus_timer.sv
// bus_timer: memory-mapped down-counting timer on a shared 16-bit CPU bus.
// Register window of four words at BASE: CTRL, LOAD, COUNT, STATUS.
// The count ticks once every PRESCALE clocks while running, and the timer
// either reloads from LOAD or stops in a one-shot done state on expiry.
// Optional feature: define BUS_TIMER_IRQ_EN to enable the interrupt output
// and the writable CTRL.irq_en bit; without it, irq is tied low.
module bus_timer #(
    parameter logic [15:0] BASE     = 16'h0010,
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Direcciones,
    input  logic        wr,
    input  logic        rd,
    inout  wire  [15:0] Datos,
    output logic        irq
);

    localparam logic [7:0] PrescMax = 8'(PRESCALE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic        run;
    logic        en;
    logic        ar_q, ar_d;
    logic        ie_q;
    logic [15:0] load_q, load_d;
    logic [15:0] count_q, count_d;
    logic        expired_q, expired_d;
    logic [7:0]  presc_q, presc_d;
    logic [15:0] rdata;

    logic        hit;
    logic [1:0]  offset;
    logic        wr_hit, wr_ctrl, wr_load, wr_count, wr_status;
    logic        tick, expire;

    assign hit       = (Direcciones[15:2] == BASE[15:2]);
    assign offset    = Direcciones[1:0];
    assign wr_hit    = wr & hit;
    assign wr_ctrl   = wr_hit & (offset == 2'd0);
    assign wr_load   = wr_hit & (offset == 2'd1);
    assign wr_count  = wr_hit & (offset == 2'd2);
    assign wr_status = wr_hit & (offset == 2'd3);

    // A CTRL or COUNT write restarts the prescaler, so it also swallows a tick
    // landing in the same cycle: the written values win outright.
    assign tick   = run & (presc_q == PrescMax) & ~wr_ctrl & ~wr_count;
    assign expire = tick & (count_q == 16'd0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: software enables/disables, one-shot expiry stops.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (wr_ctrl && Datos[0]) state_d = StRun;
            StRun: begin
                if (wr_ctrl && !Datos[0]) begin
                    state_d = StIdle;
                end else if (expire && !ar_q) begin
                    state_d = StDone;
                end
            end
            StDone: if (wr_ctrl && Datos[0]) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: CTRL.en mirrors the running state.
    always_comb begin
        run = (state_q == StRun);
        en  = run;
    end

    // Datapath next-state: register writes, prescaler and count.
    always_comb begin
        ar_d      = ar_q;
        load_d    = load_q;
        count_d   = count_q;
        expired_d = expired_q;
        presc_d   = presc_q;

        if (wr_ctrl) ar_d = Datos[1];
        if (wr_load) load_d = Datos;

        if (wr_count) begin
            count_d = Datos;
        end else if (tick) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else if (ar_q) begin
                count_d = load_q;
            end
        end

        // Set beats clear when both happen in the same cycle.
        if (wr_status && Datos[0]) expired_d = 1'b0;
        if (expire) expired_d = 1'b1;

        if (wr_ctrl || wr_count) begin
            presc_d = 8'd0;
        end else if (run) begin
            presc_d = (presc_q == PrescMax) ? 8'd0 : presc_q + 8'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_q      <= 1'b0;
            load_q    <= 16'd0;
            count_q   <= 16'd0;
            expired_q <= 1'b0;
            presc_q   <= 8'd0;
        end else begin
            ar_q      <= ar_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            presc_q   <= presc_d;
        end
    end

`ifdef BUS_TIMER_IRQ_EN
    // Interrupt enable bit and registered interrupt request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie_q <= 1'b0;
            irq  <= 1'b0;
        end else begin
            if (wr_ctrl) ie_q <= Datos[2];
            irq <= expired_q & ie_q;
        end
    end
`else
    assign ie_q = 1'b0;
    assign irq  = 1'b0;
`endif

    // Read mux for the addressed register.
    always_comb begin
        rdata = 16'd0;
        unique case (offset)
            2'd0: rdata = {13'd0, ie_q, ar_q, en};
            2'd1: rdata = load_q;
            2'd2: rdata = count_q;
            2'd3: rdata = {15'd0, expired_q};
            default: rdata = 16'd0;
        endcase
    end

    // Drive the bus only on a clean read hit; a simultaneous wr means the CPU owns it.
    assign Datos = (rd && !wr && hit && !reset) ? rdata : 16'hzzzz;

endmodule

// File: tb/tb_bus_timer.sv
// Randomized self-checking bench for bus_timer against a behavioural model.
// The bus carries pull-ups so an undriven Datos reads as 16'hFFFF.
module tb_bus_timer;

    localparam logic [15:0] BASE     = 16'h0010;
    localparam int unsigned PRESCALE = 4;
    localparam logic [15:0] HIZ      = 16'hFFFF;
`ifdef BUS_TIMER_IRQ_EN
    localparam bit IrqBuild = 1'b1;
`else
    localparam bit IrqBuild = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] Direcciones;
    logic        wr;
    logic        rd;
    tri1  [15:0] Datos;
    logic        irq;
    logic        tb_drv;
    logic [15:0] tb_val;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state.
    bit          m_en, m_ar, m_ie, m_exp, m_irq;
    int unsigned m_phase;        // clocks elapsed in the current tick period
    int unsigned m_count, m_load;

    assign Datos = tb_drv ? tb_val : 16'hzzzz;

    bus_timer #(
        .BASE     (BASE),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Direcciones (Direcciones),
        .wr          (wr),
        .rd          (rd),
        .Datos       (Datos),
        .irq         (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [1:0] off);
        case (off)
            2'd0:    return {13'd0, m_ie, m_ar, m_en};
            2'd1:    return 16'(m_load);
            2'd2:    return 16'(m_count);
            default: return {15'd0, m_exp};
        endcase
    endfunction

    task automatic m_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0; m_irq = 0;
        m_phase = 0; m_count = 0; m_load = 0;
    endtask

    // One clock of the timer rules, applied to the model.
    task automatic m_step(input logic w, input logic [15:0] a, input logic [15:0] d);
        bit hit, restart, tick, fire, clr;
        int unsigned nxt_count;
        hit     = w && (a[15:2] == BASE[15:2]);
        restart = hit && (a[1:0] == 2'd0 || a[1:0] == 2'd2);
        tick    = m_en && (m_phase == PRESCALE - 1) && !restart;
        fire    = tick && (m_count == 0);
        clr     = hit && (a[1:0] == 2'd3) && d[0];
        m_irq   = m_exp && m_ie;
        nxt_count = m_count;
        if (tick) nxt_count = (m_count != 0) ? m_count - 1 : (m_ar ? m_load : 0);
        if (restart) m_phase = 0;
        else if (m_en) m_phase = (m_phase + 1) % PRESCALE;
        if (fire && !m_ar) m_en = 0;
        m_exp = fire || (m_exp && !clr);
        if (hit) begin
            case (a[1:0])
                2'd0: begin m_en = d[0]; m_ar = d[1]; m_ie = IrqBuild && d[2]; end
                2'd1: m_load = d;
                2'd2: nxt_count = d;
                default: ;
            endcase
        end
        m_count = nxt_count;
    endtask

    // One bus cycle, entered and left just after a falling edge.
    task automatic cyc(input logic w, input logic r, input logic [15:0] a,
                       input logic [15:0] d, output logic [15:0] bus);
        logic [15:0] exp_bus;
        wr = w; rd = r; Direcciones = a; tb_drv = w; tb_val = d;
        #1;
        if (w) exp_bus = d;
        else if (r && a[15:2] == BASE[15:2]) exp_bus = m_read(a[1:0]);
        else exp_bus = HIZ;
        bus = Datos;
        check("bus", bus, exp_bus);
        @(posedge clk);
        m_step(w, a, d);
        #1;
        check("irq", {15'd0, irq}, {15'd0, m_irq});
        @(negedge clk);
        wr = 0; rd = 0; tb_drv = 0;
    endtask

    task automatic wreg(input logic [1:0] off, input logic [15:0] d);
        logic [15:0] bus;
        cyc(1'b1, 1'b0, {BASE[15:2], off}, d, bus);
    endtask

    task automatic rreg(input logic [1:0] off, output logic [15:0] v);
        cyc(1'b0, 1'b1, {BASE[15:2], off}, 16'd0, v);
    endtask

    task automatic idle(input int n);
        logic [15:0] bus;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 16'd0, bus);
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear without a clock edge.
    task automatic reset_mid();
        rd = 1; wr = 0; Direcciones = {BASE[15:2], 2'd2};
        #2 reset = 1;
        #1;
        check("rst_bus", Datos, HIZ);
        check("rst_irq", {15'd0, irq}, 16'd0);
        m_reset();
        rd = 0;
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        logic [15:0] v, a, d;
        int op;
        reset = 1; wr = 0; rd = 0; Direcciones = 0; tb_drv = 0; tb_val = 0;
        m_reset();
        repeat (2) @(negedge clk);
        reset = 0;

        // Reset state.
        for (int i = 0; i < 4; i++) begin
            rreg(2'(i), v);
            check("rst_reg", v, 16'd0);
        end
        check("rst_irq0", {15'd0, irq}, 16'd0);

        // Read decode and high-Z outside the window.
        wreg(2'd1, 16'hA5A5);
        rreg(2'd1, v);
        check("load_rd", v, 16'hA5A5);
        cyc(1'b0, 1'b1, BASE + 16'd4, 16'd0, v);
        check("miss_hiz", v, HIZ);

        // Auto-reload with interrupt.
        wreg(2'd1, 16'd3);
        wreg(2'd2, 16'd3);
        wreg(2'd0, 16'h0007);
        idle(15);
        rreg(2'd3, v);
        check("ar_pre16", v, 16'd0);
        rreg(2'd3, v);
        check("ar_exp16", v, 16'd1);
        check("ar_irq", {15'd0, irq}, {15'd0, IrqBuild});
        rreg(2'd2, v);
        check("ar_reload", v, 16'd3);
        rreg(2'd0, v);
        check("ar_ctrl", v, IrqBuild ? 16'd7 : 16'd3);
        wreg(2'd0, 16'h0000);
        wreg(2'd3, 16'h0001);
        idle(2);

        // One-shot.
        wreg(2'd2, 16'd2);
        wreg(2'd0, 16'h0005);
        idle(12);
        rreg(2'd0, v);
        check("os_ctrl", v, IrqBuild ? 16'd4 : 16'd0);
        rreg(2'd2, v);
        check("os_count", v, 16'd0);
        rreg(2'd3, v);
        check("os_exp", v, 16'd1);
        idle(8);
        rreg(2'd2, v);
        check("os_hold", v, 16'd0);
        wreg(2'd3, 16'h0001);
        idle(2);

        // Clear coinciding with expiry keeps the flag; a later clear drops irq.
        wreg(2'd2, 16'd1);
        wreg(2'd0, 16'h0007);
        idle(7);
        wreg(2'd3, 16'h0001);
        rreg(2'd3, v);
        check("clr_race", v, 16'd1);
        wreg(2'd0, 16'h0004);
        idle(1);
        wreg(2'd3, 16'h0001);
        check("clr_irq_hold", {15'd0, irq}, {15'd0, IrqBuild});
        idle(1);
        check("clr_irq_drop", {15'd0, irq}, 16'd0);

        // Reset mid-run with COUNT=5.
        wreg(2'd2, 16'd5);
        wreg(2'd0, 16'h0007);
        idle(6);
        reset_mid();
        for (int i = 0; i < 4; i++) begin
            rreg(2'(i), v);
            check("mid_rst_reg", v, 16'd0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            op = $urandom_range(0, 11);
            d  = 16'($urandom);
            if (d[15]) d = 16'($urandom_range(0, 6));
            case (op)
                0, 1: wreg(2'd0, {13'd0, 1'($urandom_range(0, 3) != 0) | d[0] , d[2:1]}
                           & 16'h0007 | {13'd0, d[2], d[1], 1'b0} | 16'(($urandom_range(0, 3) != 0))
                           );
                2:    wreg(2'd1, d);
                3:    wreg(2'd2, d);
                4:    wreg(2'd3, d);
                5, 6: begin rreg(2'($urandom_range(0, 3)), v); end
                7: begin
                    a = 16'($urandom);
                    if (a[15:2] == BASE[15:2]) a = a ^ 16'h0100;
                    cyc(1'($urandom), 1'b1, a, d, v);
                end
                8: cyc(1'b1, 1'b1, {BASE[15:2], 2'd1}, d, v);
                default: idle(1);
            endcase
            if (n % 400 == 399) reset_mid();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter BASE, default 16'h0010, base address of the 4-word register window.
REQ-002 SHALL have parameter PRESCALE, default 4, clk cycles per count tick (legal range 1..255).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port Direcciones, input, 16, CPU address bus.
REQ-006 SHALL have port wr, input, 1, CPU write strobe (CPU drives Datos).
REQ-007 SHALL have port rd, input, 1, CPU read strobe.
REQ-008 SHALL have port Datos, inout, 16, shared CPU data bus.
REQ-009 SHALL have port irq, output, 1, registered interrupt request to one CPU intr line.

Function
REQ-010 SHALL decode hit = Direcciones[15:2] == BASE[15:2]; offset = Direcciones[1:0]: 0 CTRL, 1 LOAD, 2 COUNT, 3 STATUS.
REQ-011 CTRL SHALL hold bit0 en, bit1 autoreload, bit2 irq_en; bits 15:3 read 0.
REQ-012 LOAD SHALL be 16-bit read/write; COUNT SHALL be 16-bit read/write current count; STATUS bit0 = expired, bits 15:1 read 0.
REQ-013 Read: while rd=1, wr=0, hit=1, Datos SHALL be driven combinationally with the addressed register; otherwise Datos SHALL be high-Z.
REQ-014 rd=1 and wr=1 together SHALL be treated as a write; Datos SHALL NOT be driven.
REQ-015 Write: on clk edge with wr=1, hit=1, the addressed register SHALL take Datos; STATUS write SHALL clear expired only where Datos[0]=1.
REQ-016 States SHALL be IDLE (en=0), RUN (en=1), DONE (one-shot expired, en cleared by hardware).
REQ-017 IDLE->RUN on CTRL write with en=1; RUN->IDLE on CTRL write with en=0; RUN->DONE on expiry with autoreload=0; DONE->RUN on CTRL write with en=1.
REQ-018 In RUN, 8-bit prescaler SHALL count 0..PRESCALE-1 and wrap to 0; tick SHALL assert in the cycle prescaler==PRESCALE-1.
REQ-019 On tick with COUNT!=0, COUNT SHALL decrement by 1.
REQ-020 On tick with COUNT==0: expired<=1; if autoreload, COUNT<=LOAD and stay RUN; else COUNT stays 0, en<=0, go DONE.
REQ-021 LOAD=0 with autoreload SHALL expire on every tick.
REQ-022 Prescaler SHALL reset to 0 on any write to COUNT or CTRL and SHALL hold in IDLE and DONE.
REQ-023 A COUNT write coinciding with a tick SHALL win; no decrement that cycle.
REQ-024 Expiry and STATUS clear in the same cycle: expired SHALL remain 1.
REQ-025 irq SHALL equal the registered value of expired AND irq_en, one cycle after either changes.

Reset
REQ-026 On reset=1, immediately and asynchronously: CTRL=0, LOAD=0, COUNT=0, expired=0, prescaler=0, state IDLE, irq=0, Datos high-Z.
REQ-027 Reset asserted mid-count SHALL abort the count; no expiry SHALL be recorded.

Configuration
REQ-028 Macro BUS_TIMER_IRQ_EN defined: irq behaves per REQ-025 and CTRL bit2 is writable.
REQ-029 Macro BUS_TIMER_IRQ_EN undefined: irq tied 0, CTRL bit2 reads 0 and ignores writes; expired flag still operates.

Verification
REQ-030 Reset mid-RUN with COUNT=5 -> all registers 0, irq=0, Datos high-Z in the same cycle.
REQ-031 PRESCALE=4, LOAD=3, write COUNT=3, CTRL=3'b111 -> expired=1 after 16 clk; irq=1 one cycle later; COUNT reloads to 3.
REQ-032 One-shot: COUNT=2, CTRL=3'b101 -> expired after 12 clk; CTRL reads 3'b100; COUNT holds 0; state DONE.
REQ-033 Read Direcciones=BASE+1 with LOAD=16'hA5A5, rd=1 -> Datos=16'hA5A5; Direcciones=BASE+4 -> Datos high-Z.
REQ-034 STATUS write 16'h0001 in the same cycle as expiry -> expired stays 1; a later write clears it and irq drops the next cycle.
REQ-035 Build without BUS_TIMER_IRQ_EN, run REQ-031 -> expired=1, irq stays 0, CTRL reads 3'b011.
